// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the RISC-V core.
// Sequences the shared-memory datapath through fetch, decode, execute,
// memory and writeback steps, and drives all datapath enables and selects.
// Optional build macro MC_CTRL_MEMWAIT_EN: FETCH, MEMREAD and MEMWRITE stall
// until mem_ready=1. Without it mem_ready is ignored and fixed cycle counts apply.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t     state_r;
  logic       mem_ok_s;
  logic       pcupdate_s;
  logic       branch_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;
  logic       adrsrc_s;
  logic [1:0] alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] resultsrc_s;
  logic [1:0] aluop_s;
  logic       illegal_s;

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_ok_s = mem_ready;
`else
  // Memory always completes in one cycle in this build; mem_ready is unused.
  logic unused_mem_ready_s;
  assign unused_mem_ready_s = mem_ready;
  assign mem_ok_s           = 1'b1;
`endif

  // State register with next-state sequencing; reset returns to FETCH at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:    state_r <= mem_ok_s ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_r <= S_MEMADR;
            OP_R:         state_r <= S_EXECR;
            OP_I:         state_r <= S_EXECI;
            OP_BEQ:       state_r <= S_BEQ;
            OP_JAL:       state_r <= S_JAL;
            default:      state_r <= S_HALT;
          endcase
        end
        S_MEMADR:   state_r <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state_r <= mem_ok_s ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state_r <= S_FETCH;
        S_MEMWRITE: state_r <= mem_ok_s ? S_FETCH : S_MEMWRITE;
        S_EXECR:    state_r <= S_ALUWB;
        S_EXECI:    state_r <= S_ALUWB;
        S_ALUWB:    state_r <= S_FETCH;
        S_BEQ:      state_r <= S_FETCH;
        S_JAL:      state_r <= S_ALUWB;
        S_HALT:     state_r <= S_HALT;
        // A corrupted state encoding is treated as a fault and parks the FSM.
        default:    state_r <= S_HALT;
      endcase
    end
  end

  // Moore decode of the datapath controls from the current state.
  always_comb begin
    pcupdate_s  = 1'b0;
    branch_s    = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    memwrite_s  = 1'b0;
    adrsrc_s    = 1'b0;
    alusrca_s   = 2'b00;
    alusrcb_s   = 2'b00;
    resultsrc_s = 2'b00;
    aluop_s     = 2'b00;
    illegal_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        irwrite_s   = mem_ok_s;
        pcupdate_s  = mem_ok_s;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
      end
      S_DECODE: begin
        alusrca_s = 2'b01;
        alusrcb_s = 2'b01;
      end
      S_MEMADR: begin
        alusrca_s = 2'b10;
        alusrcb_s = 2'b01;
      end
      S_MEMREAD: begin
        adrsrc_s = 1'b1;
      end
      S_MEMWB: begin
        resultsrc_s = 2'b01;
        regwrite_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECR: begin
        alusrca_s = 2'b10;
        aluop_s   = 2'b10;
      end
      S_EXECI: begin
        alusrca_s = 2'b10;
        alusrcb_s = 2'b01;
        aluop_s   = 2'b10;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
      end
      S_BEQ: begin
        alusrca_s = 2'b10;
        aluop_s   = 2'b01;
        branch_s  = 1'b1;
      end
      S_JAL: begin
        alusrca_s  = 2'b01;
        alusrcb_s  = 2'b10;
        pcupdate_s = 1'b1;
      end
      S_HALT: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
  end

  // Immediate format follows the opcode directly, independent of state.
  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // Write enables are suppressed while reset is held; selects show FETCH values.
  assign PCWrite   = ~reset & (pcupdate_s | (branch_s & Zero));
  assign IRWrite   = ~reset & irwrite_s;
  assign RegWrite  = ~reset & regwrite_s;
  assign MemWrite  = ~reset & memwrite_s;
  assign illegal   = ~reset & illegal_s;
  assign AdrSrc    = adrsrc_s;
  assign ALUSrcA   = alusrca_s;
  assign ALUSrcB   = alusrcb_s;
  assign ResultSrc = resultsrc_s;
  assign ALUOp     = aluop_s;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed plus randomized instruction streams checked
// against a per-instruction cycle-by-cycle behavioural model.
module tb_mc_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;

  int errors = 0;
  int checks = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] en_vec();
    return {PCWrite, IRWrite, RegWrite, MemWrite};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Runs one instruction (or its first 'upto' cycles). Starts and ends at a negedge.
  // Model: instruction length and which cycle carries each datapath effect.
  task automatic run_instr(input logic [6:0] o, input logic z, input logic mr,
                           input int upto, input string nm);
    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal, zc;
    logic pcw, irw, regw, memw, adr;
    int n;
    is_lw = (o == OP_LW);  is_sw = (o == OP_SW);  is_r = (o == OP_R);
    is_i  = (o == OP_I);   is_beq = (o == OP_BEQ); is_jal = (o == OP_JAL);
    n = is_lw ? 5 : (is_beq ? 3 : 4);
    for (int c = 1; c <= n && c <= upto; c++) begin
      zc = is_beq ? z : 1'($urandom_range(0, 1));
      op = o; Zero = zc; mem_ready = mr;
      #1;
      pcw  = (c == 1) || (is_jal && c == 3) || (is_beq && c == 3 && zc);
      irw  = (c == 1);
      regw = (c == n) && !is_sw && !is_beq;
      memw = is_sw && (c == 4);
      adr  = (is_lw || is_sw) && (c == 4);
      chk($sformatf("%s.c%0d.en", nm, c), {4'b0000, en_vec()}, {4'b0000, pcw, irw, regw, memw});
      chk($sformatf("%s.c%0d.imm", nm, c), {6'b000000, ImmSrc}, {6'b000000, imm_of(o)});
      chk($sformatf("%s.c%0d.adr", nm, c), {7'b0000000, AdrSrc}, {7'b0000000, adr});
      chk($sformatf("%s.c%0d.ill", nm, c), {7'b0000000, illegal}, 8'h00);
      if (c == 1) begin
        chk($sformatf("%s.fetch.srcb", nm), {6'b000000, ALUSrcB}, 8'h02);
        chk($sformatf("%s.fetch.res", nm), {6'b000000, ResultSrc}, 8'h02);
      end
      if (c == 2)
        chk($sformatf("%s.dec.srca", nm), {6'b000000, ALUSrcA}, 8'h01);
      if (c == 3 && (is_r || is_i))
        chk($sformatf("%s.exec.aluop", nm), {6'b000000, ALUOp}, 8'h02);
      if (c == 3 && is_i)
        chk($sformatf("%s.exec.srcb", nm), {6'b000000, ALUSrcB}, 8'h01);
      if (c == 3 && is_beq)
        chk($sformatf("%s.beq.aluop", nm), {6'b000000, ALUOp}, 8'h01);
      if (c == n && regw)
        chk($sformatf("%s.wb.res", nm), {6'b000000, ResultSrc}, is_lw ? 8'h01 : 8'h00);
      @(negedge clk);
    end
  endtask

  logic [6:0] legal_ops [6];

  initial begin
    legal_ops[0] = OP_LW; legal_ops[1] = OP_SW;  legal_ops[2] = OP_R;
    legal_ops[3] = OP_I;  legal_ops[4] = OP_BEQ; legal_ops[5] = OP_JAL;
    reset = 1'b1; op = 7'b0000000; Zero = 1'b0; mem_ready = 1'b1;

    // Reset state.
    @(negedge clk); #1;
    chk("rst.en", {4'b0000, en_vec()}, 8'h00);
    chk("rst.ill", {7'b0000000, illegal}, 8'h00);
    chk("rst.srcb", {6'b000000, ALUSrcB}, 8'h02);
    chk("rst.res", {6'b000000, ResultSrc}, 8'h02);
    @(negedge clk);
    reset = 1'b0;

    // Directed instructions.
    run_instr(OP_R,   1'b0, 1'b1, 9, "rtype");
    run_instr(OP_LW,  1'b0, 1'b1, 9, "lw");
    run_instr(OP_SW,  1'b0, 1'b1, 9, "sw");
    run_instr(OP_BEQ, 1'b1, 1'b1, 9, "beq_z1");
    run_instr(OP_BEQ, 1'b0, 1'b1, 9, "beq_z0");
    run_instr(OP_JAL, 1'b0, 1'b1, 9, "jal");
    run_instr(OP_I,   1'b0, 1'b1, 9, "itype");

    // Reset mid-instruction: stop in EXECR, assert reset between clock edges.
    run_instr(OP_R, 1'b0, 1'b1, 2, "rpre");
    #1;
    chk("mid.execr.aluop", {6'b000000, ALUOp}, 8'h02);
    reset = 1'b1;
    #1;
    chk("mid.rst.en", {4'b0000, en_vec()}, 8'h00);
    chk("mid.rst.srcb", {6'b000000, ALUSrcB}, 8'h02);
    chk("mid.rst.aluop", {6'b000000, ALUOp}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    run_instr(OP_R, 1'b0, 1'b1, 9, "postrst");

    // Randomized instruction stream.
    for (int k = 0; k < 40; k++) begin
      logic mr;
`ifdef MC_CTRL_MEMWAIT_EN
      mr = 1'b1;
`else
      mr = 1'($urandom_range(0, 1));
`endif
      run_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), mr, 9,
                $sformatf("rnd%0d", k));
    end

`ifdef MC_CTRL_MEMWAIT_EN
    // FETCH stall on mem_ready.
    op = OP_R; Zero = 1'b0;
    for (int s = 0; s < 3; s++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("wait.s%0d.en", s), {4'b0000, en_vec()}, 8'h00);
      chk($sformatf("wait.s%0d.srcb", s), {6'b000000, ALUSrcB}, 8'h02);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    chk("wait.go.en", {4'b0000, en_vec()}, 8'h0C);
    @(negedge clk); #1;
    chk("wait.dec.srca", {6'b000000, ALUSrcA}, 8'h01);
    @(negedge clk);
    @(negedge clk); #1;
    chk("wait.wb.en", {4'b0000, en_vec()}, 8'h02);
    @(negedge clk);
`endif

    // Illegal opcode: FETCH, DECODE, then sticky HALT.
    op = 7'b0000000; Zero = 1'b1; mem_ready = 1'b1;
    #1;
    chk("ill.fetch.en", {4'b0000, en_vec()}, 8'h0C);
    chk("ill.imm", {6'b000000, ImmSrc}, 8'h00);
    @(negedge clk); #1;
    chk("ill.dec.en", {4'b0000, en_vec()}, 8'h00);
    chk("ill.dec.flag", {7'b0000000, illegal}, 8'h00);
    @(negedge clk);
    for (int h = 0; h < 5; h++) begin
      op = legal_ops[$urandom_range(0, 5)]; Zero = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("halt.h%0d.flag", h), {7'b0000000, illegal}, 8'h01);
      chk($sformatf("halt.h%0d.en", h), {4'b0000, en_vec()}, 8'h00);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("halt.rst.flag", {7'b0000000, illegal}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    run_instr(OP_JAL, 1'b0, 1'b1, 9, "afterhalt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the RISC-V core: sequences the shared-memory multicycle datapath (single ALU, single instruction/data memory, instruction register) through fetch, decode, execute, memory and writeback steps. It replaces the single-cycle main decoder plus branch logic for the multicycle build. It drives all datapath enables and mux selects, and it stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  opcode field from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle. Used only with `MC_CTRL_MEMWAIT_EN`.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1  each  datapath write enables.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  out  2  ALU B select: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = funct-decoded.
- ImmSrc  out  2  immediate format.
- illegal  out  1  sticky unsupported-opcode flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
- PCWrite = PCUpdate | (Branch & Zero). PCUpdate and Branch are internal.
- Unlisted outputs are 0. Listed selects are as given; unlisted selects are 00.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - anything else → HALT
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, Branch=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1. Next: ALUWB (writes PC+4 to rd).
- HALT: all enables 0, illegal=1. HALT is left only by reset.
- ImmSrc is decoded combinationally from op, independent of state: lw/I-type 00, sw 01, beq 10, jal 11, others 00.

## Timing
- Reset is asynchronous: the state goes to FETCH immediately, from any state, including mid-instruction.
- While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Selects show FETCH values. illegal=0.
- Outputs are Moore (decoded from state), except PCWrite (uses Zero) and ImmSrc (uses op).
- Cycles per instruction with no wait states: lw 5; sw, R-type, I-type, jal 4; beq 3.
- The first FETCH writes happen on the first rising edge after reset deasserts.

## Configuration
- With `MC_CTRL_MEMWAIT_EN` defined:
  - FETCH: IRWrite and PCUpdate are asserted only when mem_ready=1. The FSM stays in FETCH until then.
  - MEMREAD: stays in MEMREAD until mem_ready=1.
  - MEMWRITE: holds MemWrite=1 and stays until mem_ready=1.
  - All other states ignore mem_ready.
- Without the macro: mem_ready is ignored (treated as 1), and the fixed cycle counts above apply.

## Test plan
- Reset mid-instruction: assert reset while in EXECR → state returns to FETCH asynchronously; all enables read 0 during reset; IRWrite=1 on the first cycle after release.
- R-type (op=0110011): states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 only in cycle 4, with ALUOp=10 in cycle 3.
- lw then sw: lw takes 5 cycles with RegWrite and ResultSrc=01 in cycle 5. sw takes 4 cycles with MemWrite=1 and AdrSrc=1 in cycle 4. ImmSrc is 00 for lw and 01 for sw.
- beq (op=1100011), 3 cycles: with Zero=1, PCWrite=1 in cycle 3; with Zero=0, PCWrite=0 in cycle 3.
- jal (op=1101111): PCWrite=1 in JAL, then RegWrite=1 in ALUWB; ImmSrc=11 throughout.
- Illegal opcode 0000000 → HALT after DECODE; illegal=1 and stays 1, no writes occur; only reset clears it.
- With `MC_CTRL_MEMWAIT_EN`: hold mem_ready=0 for 3 cycles in FETCH → IRWrite=0 and the FSM stays in FETCH; when mem_ready=1, IRWrite=1 and PCWrite=1, then DECODE.
